branch_update_queue: RTL and testbench

In-order queue holding branch-prediction metadata from fetch until the branch retires; sits directly downstream of `branch_history` and feeds its update ports. Each predicted branch allocates an entry carrying its PHT index, BHT index and predicted direction. Execute resolves entries out of order by tag. At retire, the head entry drives one registered predictor-update pulse with a mispredict flag.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_update_queue.sv | 84 ++++++++
 tb/tb_branch_update_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared widths and record types for the branch update queue
package branch_pkg;
   localparam int PHT_IDX_W = 7;
   localparam int BHT_IDX_W = 4;

   typedef struct packed {
      logic                 valid;
      logic                 resolved;
      logic                 pred_taken;
      logic                 actual_taken;
      logic [PHT_IDX_W-1:0] pht_idx;
      logic [BHT_IDX_W-1:0] bht_idx;
   } bq_entry_t;

   typedef struct packed {
      logic                 en;
      logic [PHT_IDX_W-1:0] pht_idx;
      logic [BHT_IDX_W-1:0] bht_idx;
      logic                 branch_en;
      logic                 mispredict;
   } bp_update_t;
endpackage

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order branch metadata queue with out-of-order resolve
// and a registered in-order predictor-update pulse at retire.
module branch_update_queue
   import branch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAG_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  logic [PHT_IDX_W-1:0] alloc_pht_index,
   input  logic [BHT_IDX_W-1:0] alloc_bht_index,
   input  logic                 alloc_pred_taken,
   output logic [TAG_W-1:0]     alloc_tag,
   input  logic                 resolve_valid,
   input  logic [TAG_W-1:0]     resolve_tag,
   input  logic                 resolve_taken,
   input  logic                 retire_ready,
   input  logic                 flush,
   output logic                 update_en,
   output logic [PHT_IDX_W-1:0] update_PHT_index,
   output logic [BHT_IDX_W-1:0] update_BHT_index,
   output logic                 branch_en,
   output logic                 mispredict,
   output logic [TAG_W:0]       count
);
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   bq_entry_t        ent [DEPTH];
   logic [TAG_W-1:0] head, tail;
   logic [TAG_W:0]   cnt;
   bp_update_t       upd;
   logic             do_alloc, do_resolve, fire;

   always_comb begin
      do_alloc   = alloc_valid && alloc_ready;
      do_resolve = resolve_valid && ent[resolve_tag].valid && !ent[resolve_tag].resolved;
      fire       = ent[head].valid && ent[head].resolved && retire_ready;
   end

   // Alloc, resolve and retire never target the same entry in one cycle:
   // tail==head with alloc implies empty, and resolve needs an unresolved entry.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ent  <= '{default: '0};
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         if (reset) upd <= '0;
         else       upd.en <= 1'b0;
      end else begin
         if (do_alloc) begin
            ent[tail] <= '{valid: 1'b1, resolved: 1'b0, pred_taken: alloc_pred_taken,
                           actual_taken: 1'b0, pht_idx: alloc_pht_index, bht_idx: alloc_bht_index};
            tail <= tail + 1'b1;
         end
         if (do_resolve) begin
            ent[resolve_tag].resolved     <= 1'b1;
            ent[resolve_tag].actual_taken <= resolve_taken;
         end
         if (fire) begin
            ent[head]          <= '0;
            head               <= head + 1'b1;
            upd.pht_idx        <= ent[head].pht_idx;
            upd.bht_idx        <= ent[head].bht_idx;
            upd.branch_en      <= ent[head].actual_taken;
            upd.mispredict     <= ent[head].actual_taken ^ ent[head].pred_taken;
         end
         upd.en <= fire;
         cnt    <= cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(fire);
      end
   end

   assign alloc_ready      = cnt != FULL_CNT;
   assign alloc_tag        = tail;
   assign count            = cnt;
   assign update_en        = upd.en;
   assign update_PHT_index = upd.pht_idx;
   assign update_BHT_index = upd.bht_idx;
   assign branch_en        = upd.branch_en;
   assign mispredict       = upd.mispredict;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: table vectors, directed corner sequences and random
// traffic, all checked against an age-ordered queue model of the branch queue.
module tb_branch_update_queue;
   localparam int DEPTH = 8;

   logic       clk, reset, alloc_valid, alloc_ready, alloc_pred_taken;
   logic [6:0] alloc_pht_index, update_PHT_index;
   logic [3:0] alloc_bht_index, update_BHT_index, count;
   logic [2:0] alloc_tag, resolve_tag;
   logic       resolve_valid, resolve_taken, retire_ready, flush;
   logic       update_en, branch_en, mispredict;

   int checks = 0;
   int failures = 0;

   branch_update_queue #(.DEPTH(8), .TAG_W(3)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_pht_index(alloc_pht_index), .alloc_bht_index(alloc_bht_index),
      .alloc_pred_taken(alloc_pred_taken), .alloc_tag(alloc_tag),
      .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
      .retire_ready(retire_ready), .flush(flush),
      .update_en(update_en), .update_PHT_index(update_PHT_index),
      .update_BHT_index(update_BHT_index), .branch_en(branch_en),
      .mispredict(mispredict), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: live branches in age order; tags follow from the oldest tag and occupancy.
   typedef struct {
      int         tag;
      logic [6:0] pht;
      logic [3:0] bht;
      bit         pred;
      bit         res;
      bit         act;
   } ment_t;

   ment_t      mq[$];
   int         mhead = 0;
   bit         e_en = 0, e_br = 0, e_mp = 0;
   logic [6:0] e_pht = '0;
   logic [3:0] e_bht = '0;

   function automatic void model_step();
      int    sz;
      int    ttag;
      bit    fire;
      ment_t t;
      sz   = mq.size();
      ttag = (mhead + sz) % DEPTH;
      fire = sz > 0 && mq[0].res && retire_ready;
      if (reset || flush) begin
         mq.delete();
         mhead = 0;
         e_en  = 0;
         if (reset) begin
            e_pht = '0; e_bht = '0; e_br = 0; e_mp = 0;
         end
         return;
      end
      if (resolve_valid)
         foreach (mq[i])
            if (mq[i].tag == int'(resolve_tag) && !mq[i].res) begin
               t = mq[i]; t.res = 1; t.act = resolve_taken; mq[i] = t;
            end
      e_en = fire;
      if (fire) begin
         t = mq.pop_front();
         e_pht = t.pht; e_bht = t.bht; e_br = t.act; e_mp = t.act ^ t.pred;
         mhead = (mhead + 1) % DEPTH;
      end
      if (alloc_valid && sz < DEPTH)
         mq.push_back('{ttag, alloc_pht_index, alloc_bht_index, alloc_pred_taken, 0, 0});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("update_en", update_en, e_en);
      chk("update_PHT_index", update_PHT_index, e_pht);
      chk("update_BHT_index", update_BHT_index, e_bht);
      chk("branch_en", branch_en, e_br);
      chk("mispredict", mispredict, e_mp);
      chk("count", count, mq.size());
      chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
      if (mq.size() < DEPTH) chk("alloc_tag", alloc_tag, (mhead + mq.size()) % DEPTH);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      alloc_valid = 0; alloc_pht_index = '0; alloc_bht_index = '0; alloc_pred_taken = 0;
      resolve_valid = 0; resolve_tag = '0; resolve_taken = 0;
      retire_ready = 0; flush = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cycle();
      reset = 0;
   endtask

   task automatic alloc(input logic [6:0] p, input logic [3:0] b, input logic pt);
      alloc_valid = 1; alloc_pht_index = p; alloc_bht_index = b; alloc_pred_taken = pt;
      cycle();
      alloc_valid = 0;
   endtask

   task automatic resolve(input logic [2:0] tg, input logic tk);
      resolve_valid = 1; resolve_tag = tg; resolve_taken = tk;
      cycle();
      resolve_valid = 0;
   endtask

   typedef struct {
      logic       av;
      logic [6:0] ap;
      logic [3:0] ab;
      logic       apt;
      logic       rv;
      logic [2:0] rt;
      logic       rtk;
      logic       rr;
      logic       x_en;
      logic [6:0] x_pht;
      logic [3:0] x_bht;
      logic       x_br;
      logic       x_mp;
      logic [3:0] x_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 7'h15, 4'h3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 4'd1};
      tbl[1] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 4'd1};
      tbl[2] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 7'h15, 4'h3, 1'b0, 1'b1, 4'd0};
      tbl[3] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 7'h15, 4'h3, 1'b0, 1'b1, 4'd0};
      tbl[4] = '{1'b1, 7'h7f, 4'hf, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 7'h15, 4'h3, 1'b0, 1'b1, 4'd1};
      tbl[5] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 7'h15, 4'h3, 1'b0, 1'b1, 4'd1};
      tbl[6] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 7'h7f, 4'hf, 1'b1, 1'b1, 4'd0};
      tbl[7] = '{1'b1, 7'h2a, 4'h5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 7'h7f, 4'hf, 1'b1, 1'b1, 4'd1};
      tbl[8] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 7'h7f, 4'hf, 1'b1, 1'b1, 4'd1};
      tbl[9] = '{1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 7'h2a, 4'h5, 1'b1, 1'b0, 4'd0};

      reset = 1;
      idle();
      cycle();
      cycle();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_count", count, 0);
      chk("rst_update_en", update_en, 0);
      reset = 0;

      foreach (tbl[i]) begin
         alloc_valid = tbl[i].av; alloc_pht_index = tbl[i].ap; alloc_bht_index = tbl[i].ab;
         alloc_pred_taken = tbl[i].apt; resolve_valid = tbl[i].rv; resolve_tag = tbl[i].rt;
         resolve_taken = tbl[i].rtk; retire_ready = tbl[i].rr; flush = 0;
         cycle();
         chk("tbl_update_en", update_en, tbl[i].x_en);
         chk("tbl_pht", update_PHT_index, tbl[i].x_pht);
         chk("tbl_bht", update_BHT_index, tbl[i].x_bht);
         chk("tbl_branch_en", branch_en, tbl[i].x_br);
         chk("tbl_mispredict", mispredict, tbl[i].x_mp);
         chk("tbl_count", count, tbl[i].x_cnt);
      end

      // Fill, refuse the ninth, and no bypass from a same-cycle retire.
      do_reset();
      alloc_valid = 1;
      for (int i = 0; i < 8; i++) begin
         alloc_pht_index = 7'(i + 32); alloc_bht_index = 4'(i); alloc_pred_taken = i[0];
         cycle();
      end
      chk("full_count", count, 8);
      chk("full_ready", alloc_ready, 0);
      cycle();
      chk("ninth_ignored", count, 8);
      alloc_valid = 0;
      resolve(3'd0, 1'b1);
      retire_ready = 1; alloc_valid = 1;
      cycle();
      chk("full_retire_en", update_en, 1);
      chk("full_retire_pht", update_PHT_index, 32);
      chk("full_alloc_refused", count, 7);
      chk("wrap_ready", alloc_ready, 1);
      chk("wrap_tag", alloc_tag, 0);
      idle();

      // Out-of-order resolve, in-order update stream.
      do_reset();
      for (int i = 0; i < 4; i++) alloc(7'(16 + i), 4'(i), 1'b0);
      retire_ready = 1;
      resolve(3'd3, 1'b1); chk("ooo_wait3", update_en, 0);
      resolve(3'd1, 1'b1); chk("ooo_wait1", update_en, 0);
      resolve(3'd2, 1'b1); chk("ooo_wait2", update_en, 0);
      resolve(3'd0, 1'b1); chk("ooo_wait0", update_en, 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("ooo_en", update_en, 1);
         chk("ooo_order", update_PHT_index, 16 + i);
      end
      cycle();
      chk("ooo_done", update_en, 0);
      idle();

      // Second resolve of the same tag is ignored.
      do_reset();
      for (int i = 0; i < 3; i++) alloc(7'(64 + i), 4'(i), 1'b0);
      resolve(3'd2, 1'b1);
      resolve(3'd2, 1'b0);
      resolve(3'd0, 1'b0);
      resolve(3'd1, 1'b0);
      retire_ready = 1;
      cycle(); cycle(); cycle();
      chk("dbl_en", update_en, 1);
      chk("dbl_pht", update_PHT_index, 66);
      chk("dbl_branch_en", branch_en, 1);
      chk("dbl_mispredict", mispredict, 1);
      idle();

      // Flush coinciding with a retire fire.
      do_reset();
      for (int i = 0; i < 5; i++) alloc(7'(80 + i), 4'(i), 1'b1);
      resolve(3'd0, 1'b1); resolve(3'd1, 1'b0); resolve(3'd2, 1'b1);
      retire_ready = 1; flush = 1;
      cycle();
      chk("flush_en", update_en, 0);
      chk("flush_count", count, 0);
      chk("flush_tag", alloc_tag, 0);
      flush = 0;
      cycle();
      chk("flush_no_late", update_en, 0);
      idle();

      // Reset while an update is streaming out.
      do_reset();
      alloc(7'h55, 4'ha, 1'b0); alloc(7'h33, 4'h6, 1'b1);
      resolve(3'd0, 1'b1); resolve(3'd1, 1'b0);
      retire_ready = 1;
      cycle();
      chk("mid_en", update_en, 1);
      chk("mid_pht", update_PHT_index, 7'h55);
      reset = 1;
      cycle();
      reset = 0;
      chk("mid_rst_en", update_en, 0);
      chk("mid_rst_pht", update_PHT_index, 0);
      chk("mid_rst_bht", update_BHT_index, 0);
      chk("mid_rst_br", branch_en, 0);
      chk("mid_rst_mp", mispredict, 0);
      chk("mid_rst_count", count, 0);
      resolve(3'd1, 1'b1);
      cycle(); cycle();
      chk("mid_stale_resolve", update_en, 0);
      idle();

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         alloc_valid      = ($urandom_range(0, 9) < 6);
         alloc_pht_index  = 7'($urandom);
         alloc_bht_index  = 4'($urandom);
         alloc_pred_taken = 1'($urandom);
         resolve_valid    = 1'($urandom);
         resolve_taken    = 1'($urandom);
         resolve_tag      = 3'($urandom);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            resolve_tag = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
         retire_ready     = ($urandom_range(0, 9) < 7);
         flush            = ($urandom_range(0, 99) < 2);
         reset            = ($urandom_range(0, 99) < 1);
         cycle();
      end
      reset = 0;
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
